// File: rtl/sal_ddr_params_pkg.sv
// -----------------------------------------------------------------------------
// sal_ddr_params_pkg
// Shared DDR controller parameters: timer widths, refresh-debt limits and the
// refresh controller FSM state encoding.
// -----------------------------------------------------------------------------
package sal_ddr_params_pkg;
   localparam int REFI_W = 16;   // refresh interval counter width
   localparam int RFC_W  = 10;   // refresh busy counter width
   localparam int PEND_W = 4;    // refresh debt counter width

   localparam logic [PEND_W-1:0] MAX_PEND  = 4'd8;  // debt saturation point
   localparam logic [PEND_W-1:0] URGENT_TH = 4'd7;  // debt level flagged urgent

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RFC  = 2'd2
   } ref_state_e;
endpackage

// File: rtl/sal_tick_gen.sv
// -----------------------------------------------------------------------------
// sal_tick_gen
// Periodic tick generator for maintenance timers. A down-counter reloads to
// period_i-1 and emits a one-cycle tick when it reaches zero, so ticks are
// period_i cycles apart. When disabled it sits at period_i-1 and never ticks.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset (counter loads period_i-1)
//   en_i      in   count enable
//   period_i  in   CNT_W  tick period in clk cycles (>= 2)
//   tick_o    out  one-cycle tick, combinational from the counter
// -----------------------------------------------------------------------------
module sal_tick_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] reload;

   // period_i is only consumed through reload, so a new period takes effect
   // at the next reload (or reset / while disabled), never mid-interval.
   assign reload = period_i - CNT_W'(1);

   always_comb begin
      tick_o = 1'b0;
      cnt_d  = cnt_q;
      if (!en_i) begin
         cnt_d = reload;
      end else if (cnt_q == '0) begin
         tick_o = 1'b1;
         cnt_d  = reload;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= reload;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sal_ref_ctrl.sv
// -----------------------------------------------------------------------------
// sal_ref_ctrl
// DDR refresh controller. Accumulates refresh debt from a periodic interval
// tick, requests refreshes from the bank controller, waits out tRFC after each
// granted REF, and flags urgency and debt overflow.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   synchronous active-low reset
//   ref_en_i      in   interval timer enable
//   t_refi_i      in   REFI_W  refresh interval in cycles (>= 2)
//   t_rfc_i       in   RFC_W   refresh busy time in cycles (>= 1)
//   ref_req_o     out  refresh request to bank controller
//   ref_gnt_i     in   REF issued by bank controller
//   ref_urgent_o  out  request pending with debt >= URGENT_TH
//   pend_cnt_o    out  4  outstanding refresh debt (0..MAX_PEND)
//   ref_ovf_o     out  sticky debt overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module sal_ref_ctrl
   import sal_ddr_params_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ref_en_i,
   input  logic [REFI_W-1:0] t_refi_i,
   input  logic [RFC_W-1:0]  t_rfc_i,
   output logic              ref_req_o,
   input  logic              ref_gnt_i,
   output logic              ref_urgent_o,
   output logic [PEND_W-1:0] pend_cnt_o,
   output logic              ref_ovf_o
);

   ref_state_e        state_q, state_d;
   logic [PEND_W-1:0] pend_q,  pend_d;
   logic [RFC_W-1:0]  busy_q,  busy_d;
   logic              req_q,   req_d;
   logic              urg_q,   urg_d;
   logic              ovf_q,   ovf_d;
   logic              tick;
   logic              gnt_ok;

   sal_tick_gen #(
      .CNT_W (REFI_W)
   ) u_tick_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (ref_en_i),
      .period_i (t_refi_i),
      .tick_o   (tick)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      // A grant only counts while we are actually requesting.
      gnt_ok  = ref_gnt_i && (state_q == REQ);

      if (tick && !gnt_ok) begin
         if (pend_q == MAX_PEND) ovf_d  = 1'b1;
         else                    pend_d = pend_q + PEND_W'(1);
      end else if (!tick && gnt_ok) begin
         pend_d = pend_q - PEND_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (pend_d != '0) state_d = REQ;
         end
         REQ: begin
            if (gnt_ok) begin
               state_d = RFC;
               busy_d  = t_rfc_i - RFC_W'(1);
            end
         end
         RFC: begin
            if (busy_q == '0) state_d = (pend_d != '0) ? REQ : IDLE;
            else              busy_d  = busy_q - RFC_W'(1);
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state so ref_req_o rises in the same
      // cycle pend_cnt_o first shows the new debt.
      req_d = (state_d == REQ);
      urg_d = req_d && (pend_d >= URGENT_TH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         busy_q  <= '0;
         req_q   <= 1'b0;
         urg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         req_q   <= req_d;
         urg_q   <= urg_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ref_req_o    = req_q;
   assign ref_urgent_o = urg_q;
   assign pend_cnt_o   = pend_q;
   assign ref_ovf_o    = ovf_q;

endmodule
